register_file_mp: RTL and testbench

//  Parametrised multi-read-port register file with byte-enabled writes, an optional hardwired-zero entry,
//  and a self-clearing sequencer that zeroes every entry after reset or on request.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_clear_seq.sv | 58 +++++
 rtl/register_file_mp.sv | 75 +++++++
 tb/tb_register_file_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Byte merge is wrapped in a parameterised class so any entry width can use it.
package regfile_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

    virtual class rf_util #(parameter int W = 32);
        static function logic [W-1:0] byte_merge(
            input logic [W-1:0]   prev,
            input logic [W-1:0]   wdat,
            input logic [W/8-1:0] be
        );
            logic [W-1:0] res;
            res = prev;
            for (int b = 0; b < W/8; b++) begin
                if (be[b]) res[8*b +: 8] = wdat[8*b +: 8];
            end
            return res;
        endfunction
    endclass

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry after reset or on a clear request,
// emitting one zero-write per cycle and holding busy until the last entry.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int R = 256,
    parameter int L = 8
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         clear_i,
    output logic         busy,
    output logic         clr_we,
    output logic [L-1:0] clr_addr
);

    localparam logic [L:0] LAST = (L+1)'(R - 1);

    rf_state_e  state;
    rf_state_e  state_next;
    logic [L:0] cnt;
    logic [L:0] cnt_next;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RF_IDLE: begin
                if (clear_i) begin
                    state_next = RF_CLEAR;
                    cnt_next   = '0;
                end
            end
            RF_CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) state_next = RF_IDLE;
            end
            default: state_next = RF_CLEAR;
        endcase
    end

    always_comb begin
        busy     = (state == RF_CLEAR);
        clr_we   = (state == RF_CLEAR);
        clr_addr = cnt[L-1:0];
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enabled writes and self-clearing.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int R        = 256,
    parameter int W        = 32,
    parameter int L        = 8,
    parameter int NR       = 2,
    parameter int ZERO_REG = 0
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic            wen_i,
    input  logic [L-1:0]    wa_i,
    input  logic [W-1:0]    wd_i,
    input  logic [W/8-1:0]  be_i,
    input  logic [NR*L-1:0] ra_i,
    output logic [NR*W-1:0] rd_o,
    output logic            busy_o
);

    logic [W-1:0] rf [R];

    logic         busy;
    logic         clr_we;
    logic [L-1:0] clr_addr;
    logic         wr_hit;
    logic [W-1:0] wr_val;

    regfile_clear_seq #(
        .R(R),
        .L(L)
    ) u_clear_seq (
        .clk     (clk),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign busy_o = busy;

    // A write to the hardwired zero entry never counts as a hit.
    assign wr_hit = wen_i && !busy && !(ZERO_REG != 0 && wa_i == '0);
    assign wr_val = rf_util#(W)::byte_merge(rf[wa_i], wd_i, be_i);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            rf[clr_addr] <= '0;
        end else if (wr_hit && !reset_i) begin
            rf[wa_i] <= wr_val;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [L-1:0] ra;
        logic [W-1:0] rdv;

        assign ra = ra_i[k*L +: L];

        always_comb begin
            rdv = rf[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && wa_i == ra) rdv = wr_val;
`endif
            if (busy || (ZERO_REG != 0 && ra == '0)) rdv = '0;
        end

        assign rd_o[k*W +: W] = rdv;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (plain and zero-register builds).
module tb_register_file_mp;

    localparam int R  = 256;
    localparam int W  = 32;
    localparam int L  = 8;
    localparam int NR = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic            clear_i = 1'b0;
    logic            wen_i = 1'b0;
    logic [L-1:0]    wa_i = '0;
    logic [W-1:0]    wd_i = '0;
    logic [W/8-1:0]  be_i = '0;
    logic [NR*L-1:0] ra_i = '0;
    logic [NR*W-1:0] rd_o;
    logic [NR*W-1:0] rd_z;
    logic            busy_o;
    logic            busy_z;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_mp #(.R(R), .W(W), .L(L), .NR(NR), .ZERO_REG(0)) dut (
        .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .wen_i(wen_i),
        .wa_i(wa_i), .wd_i(wd_i), .be_i(be_i), .ra_i(ra_i),
        .rd_o(rd_o), .busy_o(busy_o)
    );

    register_file_mp #(.R(R), .W(W), .L(L), .NR(NR), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .wen_i(wen_i),
        .wa_i(wa_i), .wd_i(wd_i), .be_i(be_i), .ra_i(ra_i),
        .rd_o(rd_z), .busy_o(busy_z)
    );

    // Model: memory arrays plus a count of remaining clear cycles.
    logic [W-1:0] mem  [R];
    logic [W-1:0] memz [R];
    int clr_left = 0;
    int clr_pos = 0;
    bit valid = 1'b0;

    function automatic logic [W-1:0] merge(logic [W-1:0] prev,
                                           logic [W-1:0] wdat,
                                           logic [3:0] be);
        logic [W-1:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (prev & ~m) | (wdat & m);
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            clr_left = R;
            clr_pos  = 0;
            valid    = 1'b1;
        end else if (clr_left > 0) begin
            mem[clr_pos]  = '0;
            memz[clr_pos] = '0;
            clr_pos++;
            clr_left--;
        end else begin
            if (wen_i) begin
                mem[wa_i] = merge(mem[wa_i], wd_i, be_i);
                if (wa_i != 0) memz[wa_i] = merge(memz[wa_i], wd_i, be_i);
            end
            if (clear_i) begin
                clr_left = R;
                clr_pos  = 0;
            end
        end
    end

    function automatic logic [W-1:0] exp_rd(bit z, int k);
        logic [L-1:0] a;
        logic [W-1:0] v;
        a = ra_i[k*L +: L];
        if (clr_left > 0) return '0;
        if (z && a == 0) return '0;
        v = z ? memz[a] : mem[a];
        if (BYP && wen_i && wa_i == a && !(z && wa_i == 0))
            v = merge(v, wd_i, be_i);
        return v;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            chk("busy", W'(busy_o), W'(clr_left > 0));
            chk("busy_z", W'(busy_z), W'(clr_left > 0));
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("rd%0d", k), rd_o[k*W +: W], exp_rd(1'b0, k));
                chk($sformatf("rdz%0d", k), rd_z[k*W +: W], exp_rd(1'b1, k));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle per iteration and counts busy cycles until idle.
    task automatic run_busy(input int wen_at, input int clr_at,
                            input int rst_at, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            wen_i   = (i == wen_at);
            wa_i    = 8'd20;
            wd_i    = 32'hFFFF_FFFF;
            be_i    = 4'hF;
            clear_i = (i == clr_at);
            reset_i = (i == rst_at);
            @(negedge clk);
            if (!busy_o) break;
            n++;
            step();
        end
        wen_i   = 1'b0;
        clear_i = 1'b0;
        reset_i = 1'b0;
        step();
    endtask

    task automatic scan_zero(string name);
        for (int a = 0; a < R; a++) begin
            ra_i = {a[7:0], a[7:0]};
            @(negedge clk);
            chk(name, rd_o[W-1:0] | rd_o[2*W-1:W], 32'h0);
            step();
        end
    endtask

    initial begin
        int n;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        run_busy(-1, -1, -1, n);
        chk("reset_busy_len", W'(n), 32'd256);
        scan_zero("reset_scan");

        ra_i  = {8'd5, 8'd5};
        wen_i = 1'b1; wa_i = 8'd5; wd_i = 32'hDEAD_BEEF; be_i = 4'b1111;
        step();
        wd_i = 32'h1122_3344; be_i = 4'b0101;
        step();
        wen_i = 1'b0;
        @(negedge clk);
        chk("merge_p0", rd_o[W-1:0], 32'hDE22_BE44);
        chk("merge_p1", rd_o[2*W-1:W], 32'hDE22_BE44);
        step();
        wen_i = 1'b1; wd_i = 32'h0; be_i = 4'b0000;
        step();
        wen_i = 1'b0;
        @(negedge clk);
        chk("be0_noop", rd_o[W-1:0], 32'hDE22_BE44);
        step();

        ra_i  = {8'd0, 8'd9};
        wen_i = 1'b1; wa_i = 8'd9; wd_i = 32'hA5A5_A5A5; be_i = 4'hF;
        @(negedge clk);
        chk("bypass_same", rd_o[W-1:0], BYP ? 32'hA5A5_A5A5 : 32'h0);
        step();
        wen_i = 1'b0;
        @(negedge clk);
        chk("bypass_next", rd_o[W-1:0], 32'hA5A5_A5A5);
        step();

        ra_i  = {8'd0, 8'd0};
        wen_i = 1'b1; wa_i = 8'd0; wd_i = 32'hFFFF_FFFF; be_i = 4'hF;
        @(negedge clk);
        chk("zero_same_p0", rd_z[W-1:0], 32'h0);
        chk("zero_same_p1", rd_z[2*W-1:W], 32'h0);
        step();
        wen_i = 1'b0;
        @(negedge clk);
        chk("zero_next_p0", rd_z[W-1:0], 32'h0);
        chk("zero_next_p1", rd_z[2*W-1:W], 32'h0);
        chk("nonzero_a0", rd_o[W-1:0], 32'hFFFF_FFFF);
        step();

        wen_i = 1'b1; wa_i = 8'd20; wd_i = 32'h55; be_i = 4'hF;
        step();
        wen_i   = 1'b0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        run_busy(3, 10, -1, n);
        chk("clear_busy_len", W'(n), 32'd256);
        ra_i = {8'd20, 8'd20};
        @(negedge clk);
        chk("clear_drop_wr", rd_o[W-1:0], 32'h0);
        step();

        wen_i = 1'b1; wa_i = 8'd200; wd_i = 32'h1234_5678; be_i = 4'hF;
        step();
        wen_i   = 1'b0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        run_busy(-1, -1, 100, n);
        chk("restart_busy_len", W'(n), 32'd357);
        scan_zero("restart_scan");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
